// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS-subset control unit:
// opcodes, functs, FSM states, instruction classes and datapath codes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_LUI = 2'b10;
  localparam logic [1:0] WB_PC4 = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_IALU,
    C_LUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_ILL
  } cls_t;

endpackage

// File: rtl/mc_cu_if.sv
// Control-unit <-> datapath bundle.
// master = control unit, slave = datapath.
interface mc_cu_if;
  logic [31:0] inst;
  logic        mem_ready;
  logic        alu_zero;
  logic        pc_we;
  logic        ir_we;
  logic        mem_re;
  logic        mem_we;
  logic        reg_we;
  logic [1:0]  pc_src;
  logic [1:0]  reg_dst;
  logic        alu_src_b;
  logic [2:0]  alu_op;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    input  inst, mem_ready, alu_zero,
    output pc_we, ir_we, mem_re, mem_we,
    output reg_we, pc_src, reg_dst,
    output alu_src_b, alu_op, wb_sel,
    output illegal, state
  );

  modport slave (
    output inst, mem_ready, alu_zero,
    input  pc_we, ir_we, mem_re, mem_we,
    input  reg_we, pc_src, reg_dst,
    input  alu_src_b, alu_op, wb_sel,
    input  illegal, state
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder:
// instruction word -> class, ALU operation, illegal.
module mc_decode
  import mc_pkg::*;
#(
  parameter bit SUPPORT_JAL = 1'b1
) (
  input  logic [31:0] i_inst,
  output cls_t        o_cls,
  output logic [2:0]  o_alu_op,
  output logic        o_illegal
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_unused_bits;
  logic       w_is_r, w_is_addiu, w_is_andi;
  logic       w_is_ori, w_is_lui, w_is_lw;
  logic       w_is_sw, w_is_beq, w_is_bne;
  logic       w_is_j, w_is_jal;

  assign w_op = i_inst[31:26];
  assign w_fn = i_inst[5:0];
  assign w_unused_bits = ^i_inst[25:6];

  assign w_is_r     = (w_op == OP_RTYPE);
  assign w_is_addiu = (w_op == OP_ADDIU);
  assign w_is_andi  = (w_op == OP_ANDI);
  assign w_is_ori   = (w_op == OP_ORI);
  assign w_is_lui   = (w_op == OP_LUI);
  assign w_is_lw    = (w_op == OP_LW);
  assign w_is_sw    = (w_op == OP_SW);
  assign w_is_beq   = (w_op == OP_BEQ);
  assign w_is_bne   = (w_op == OP_BNE);
  assign w_is_j     = (w_op == OP_J);
  assign w_is_jal   = (w_op == OP_JAL) && SUPPORT_JAL;

  // Map opcode/funct to class and ALU op; anything unmatched is illegal
  always_comb begin
    o_cls    = C_ILL;
    o_alu_op = ALU_ADD;
    unique case (1'b1)
      w_is_r: begin
        case (w_fn)
          FN_ADD: begin o_cls = C_RTYPE; o_alu_op = ALU_ADD; end
          FN_SUB: begin o_cls = C_RTYPE; o_alu_op = ALU_SUB; end
          FN_AND: begin o_cls = C_RTYPE; o_alu_op = ALU_AND; end
          FN_OR:  begin o_cls = C_RTYPE; o_alu_op = ALU_OR;  end
          FN_SLT: begin o_cls = C_RTYPE; o_alu_op = ALU_SLT; end
          default: o_cls = C_ILL;
        endcase
      end
      w_is_addiu: begin o_cls = C_IALU; o_alu_op = ALU_ADD; end
      w_is_andi:  begin o_cls = C_IALU; o_alu_op = ALU_AND; end
      w_is_ori:   begin o_cls = C_IALU; o_alu_op = ALU_OR;  end
      w_is_lui:   o_cls = C_LUI;
      w_is_lw:    begin o_cls = C_LW;  o_alu_op = ALU_ADD; end
      w_is_sw:    begin o_cls = C_SW;  o_alu_op = ALU_ADD; end
      w_is_beq:   begin o_cls = C_BEQ; o_alu_op = ALU_SUB; end
      w_is_bne:   begin o_cls = C_BNE; o_alu_op = ALU_SUB; end
      w_is_j:     o_cls = C_J;
      w_is_jal:   o_cls = C_JAL;
      default:    o_cls = C_ILL;
    endcase
  end

  assign o_illegal = (o_cls == C_ILL);

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Outputs follow state plus same-cycle mem_ready/alu_zero.
module mc_cu
  import mc_pkg::*;
#(
  parameter bit MEM_WAIT    = 1'b1,
  parameter bit SUPPORT_JAL = 1'b1
) (
  input logic     clk,
  input logic     rst,
  mc_cu_if.master bus
);

  state_t     r_state;
  logic       r_illegal;
  cls_t       w_cls;
  logic [2:0] w_alu_op;
  logic       w_ill;
  logic       w_rdy;
  logic       w_taken;

  mc_decode #(
    .SUPPORT_JAL(SUPPORT_JAL)
  ) u_dec (
    .i_inst   (bus.inst),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op),
    .o_illegal(w_ill)
  );

  assign w_rdy   = MEM_WAIT ? bus.mem_ready : 1'b1;
  assign w_taken = ((w_cls == C_BEQ) && bus.alu_zero)
                || ((w_cls == C_BNE) && !bus.alu_zero);

  // State sequencing and the sticky trap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:
          if (w_rdy) r_state <= S_DECODE;
        S_DECODE:
          if (w_ill) begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end else if (w_cls == C_J || w_cls == C_JAL)
            r_state <= S_FETCH;
          else if (w_cls == C_LUI)
            r_state <= S_WB;
          else
            r_state <= S_EXEC;
        S_EXEC:
          if (w_cls == C_LW || w_cls == C_SW)
            r_state <= S_MEM;
          else if (w_cls == C_BEQ || w_cls == C_BNE)
            r_state <= S_FETCH;
          else
            r_state <= S_WB;
        S_MEM:
          if (w_rdy)
            r_state <= (w_cls == C_LW) ? S_WB : S_FETCH;
        S_WB:
          r_state <= S_FETCH;
        S_TRAP:
          r_state <= S_TRAP;
        default:
          r_state <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls; rst masks the fetch-complete strobes
  always_comb begin
    bus.pc_we     = 1'b0;
    bus.ir_we     = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.reg_we    = 1'b0;
    bus.pc_src    = PC_PLUS4;
    bus.reg_dst   = RD_RT;
    bus.alu_src_b = 1'b0;
    bus.alu_op    = ALU_ADD;
    bus.wb_sel    = WB_ALU;
    case (r_state)
      S_FETCH: begin
        bus.mem_re = 1'b1;
        if (w_rdy && !rst) begin
          bus.ir_we  = 1'b1;
          bus.pc_we  = 1'b1;
          bus.pc_src = PC_PLUS4;
        end
      end
      S_DECODE: begin
        if (w_cls == C_J || w_cls == C_JAL) begin
          bus.pc_we  = 1'b1;
          bus.pc_src = PC_JUMP;
        end
        if (w_cls == C_JAL) begin
          bus.reg_we  = 1'b1;
          bus.reg_dst = RD_RA;
          bus.wb_sel  = WB_PC4;
        end
      end
      S_EXEC: begin
        bus.alu_op    = w_alu_op;
        bus.alu_src_b = (w_cls == C_IALU) || (w_cls == C_LW)
                     || (w_cls == C_SW);
        if (w_taken) begin
          bus.pc_we  = 1'b1;
          bus.pc_src = PC_BRANCH;
        end
      end
      S_MEM: begin
        bus.mem_re = (w_cls == C_LW);
        bus.mem_we = (w_cls == C_SW);
      end
      S_WB: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = (w_cls == C_RTYPE) ? RD_RD : RD_RT;
        if (w_cls == C_LW)
          bus.wb_sel = WB_MEM;
        else if (w_cls == C_LUI)
          bus.wb_sel = WB_LUI;
        else
          bus.wb_sel = WB_ALU;
      end
      default: ;
    endcase
  end

  assign bus.state   = r_state;
  assign bus.illegal = r_illegal;

endmodule
